// File: rtl/lcd_spi_sequencer.sv
// ILI9341 link sequencer: buffers {DC, byte} words, runs the LCD_RESX power-up
// timing, then hands bytes one at a time to the SPI controller via LOAD/BUSY.
module lcd_spi_sequencer #(
    parameter int FIFO_DEPTH      = 16,
    parameter int RST_LOW_CYCLES  = 1000000,
    parameter int RST_WAIT_CYCLES = 12000000
) (
    input  logic       CLK_100MHz,
    input  logic       RESET_N,
    input  logic       WR,
    input  logic [8:0] DIN,
    output logic       FULL,
    output logic       EMPTY,
    output logic       OVERFLOW,
    input  logic       CLR_OVF,
    output logic       READY,
    output logic       IDLE,
    output logic       SPI_LOAD,
    output logic [7:0] SPI_IN,
    input  logic       SPI_BUSY,
    output logic       LCD_DC,
    output logic       LCD_RESX
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    // A zero-cycle request behaves as a single cycle.
    localparam logic [31:0] LOW_LAST  = (RST_LOW_CYCLES  > 1) ? 32'(RST_LOW_CYCLES  - 1) : 32'd0;
    localparam logic [31:0] WAIT_LAST = (RST_WAIT_CYCLES > 1) ? 32'(RST_WAIT_CYCLES - 1) : 32'd0;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } word_t;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        IDLE_ST,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t        state, state_d;
    logic [31:0]   cnt, cnt_d;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    word_t         mem [FIFO_DEPTH];
    word_t         head;
    logic          full_now, push, pop;
    logic          load_d, dc_d, resx_d, ready_d;
    logic [7:0]    spi_in_d;

    // FULL is judged on the pre-edge count, so a pop never frees room for a
    // push on the same edge.
    assign full_now = (count == DEPTH_C);
    assign push     = WR && !full_now;
    assign head     = mem[rd_ptr];

    always_ff @(posedge CLK_100MHz) begin
        if (push) mem[wr_ptr] <= word_t'(DIN);
    end

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= RST_LOW;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        pop      = 1'b0;
        load_d   = 1'b0;
        spi_in_d = SPI_IN;
        dc_d     = LCD_DC;
        resx_d   = LCD_RESX;
        ready_d  = READY;
        case (state)
            RST_LOW: begin
                resx_d = 1'b0;
                if (cnt == LOW_LAST) begin
                    state_d = RST_WAIT;
                    cnt_d   = '0;
                    resx_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            RST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_d = IDLE_ST;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            IDLE_ST: begin
                if (count != '0 && !SPI_BUSY) begin
                    pop      = 1'b1;
                    spi_in_d = head.data;
                    dc_d     = head.dc;
                    load_d   = 1'b1;
                    state_d  = WAIT_START;
                end
            end
            WAIT_START: begin
                if (SPI_BUSY) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!SPI_BUSY) state_d = IDLE_ST;
            end
            default: state_d = RST_LOW;
        endcase
    end

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            SPI_LOAD <= 1'b0;
            SPI_IN   <= '0;
            LCD_DC   <= 1'b0;
            LCD_RESX <= 1'b0;
            READY    <= 1'b0;
            FULL     <= 1'b0;
            EMPTY    <= 1'b1;
            OVERFLOW <= 1'b0;
            IDLE     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_d;
            SPI_LOAD <= load_d;
            SPI_IN   <= spi_in_d;
            LCD_DC   <= dc_d;
            LCD_RESX <= resx_d;
            READY    <= ready_d;
            FULL     <= (count_d == DEPTH_C);
            EMPTY    <= (count_d == '0);
            IDLE     <= ready_d && (count_d == '0) && (state_d == IDLE_ST) && !SPI_BUSY;
            // A refused write wins over a clear on the same edge.
            if (WR && full_now)
                OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                OVERFLOW <= 1'b0;
        end
    end

endmodule
